// File: rtl/mult_acc_pkg.sv
// Shared types and helpers for the product accumulator.
// The widened add keeps the carry so overflow falls out of the sum itself.
package mult_acc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } acc_state_t;

  localparam int unsigned ADD_MAX_W = 64;

  function automatic int unsigned cnt_width(input int unsigned len);
    return $clog2(len + 1);
  endfunction

  // Operands are zero-extended by the caller; the carry for a W-bit add lands at bit W.
  function automatic logic [ADD_MAX_W:0] add_ovf(input logic [ADD_MAX_W-1:0] a,
                                                 input logic [ADD_MAX_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/acc_add_sat.sv
// Combinational accumulate step: acc + product with carry-out as overflow.
// Define MULT_ACC_SATURATE_EN to clamp at all-ones on overflow instead of wrapping.
module acc_add_sat
  import mult_acc_pkg::*;
#(
  parameter int ACC_W  = 16,
  parameter int PROD_W = 8
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [PROD_W-1:0] prod_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              ovf_o
);

  logic [ADD_MAX_W:0] full;
  logic               unused_hi;

  assign full      = add_ovf(ADD_MAX_W'(acc_i), ADD_MAX_W'(prod_i));
  assign ovf_o     = full[ACC_W];
  assign unused_hi = ^full[ADD_MAX_W:ACC_W+1];

`ifdef MULT_ACC_SATURATE_EN
  // Once clamped, any further non-zero product overflows again, so the clamp sticks.
  assign sum_o = ovf_o ? '1 : full[ACC_W-1:0];
`else
  assign sum_o = full[ACC_W-1:0];
`endif

endmodule

// File: rtl/mult_accumulator.sv
// Frames up to LEN product beats into a wide sum, presented on a valid/ready output.
// Optional clamp on overflow is selected in acc_add_sat by MULT_ACC_SATURATE_EN.
module mult_accumulator
  import mult_acc_pkg::*;
#(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 16,
  parameter int LEN    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PROD_W-1:0]        in_product,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W-1:0]         out_sum,
  output logic [$clog2(LEN+1)-1:0] out_count,
  output logic                     out_overflow
);

  localparam int CNT_W = cnt_width(LEN);

  acc_state_t       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic [ACC_W-1:0] add_sum;
  logic             add_carry;
  logic [CNT_W-1:0] count_inc;

  acc_add_sat #(
    .ACC_W (ACC_W),
    .PROD_W(PROD_W)
  ) u_add (
    .acc_i (acc_q),
    .prod_i(in_product),
    .sum_o (add_sum),
    .ovf_o (add_carry)
  );

  assign in_ready  = (state_q != HOLD) | out_ready;
  assign accept    = in_valid & in_ready;
  assign count_inc = count_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          acc_d   = add_sum;
          ovf_d   = ovf_q | add_carry;
          count_d = count_inc;
          if (in_last || (count_inc == CNT_W'(LEN))) state_d = HOLD;
        end
      end
      IDLE, HOLD: begin
        if (state_q == HOLD && out_ready) state_d = IDLE;
        // A beat taken during handoff opens the next frame with no bubble.
        if (accept) begin
          acc_d   = ACC_W'(in_product);
          count_d = CNT_W'(1);
          ovf_d   = 1'b0;
          state_d = (LEN == 1 || in_last) ? HOLD : ACCUM;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Outputs come straight from state registers; they only move outside HOLD.
  assign out_valid    = (state_q == HOLD);
  assign out_sum      = acc_q;
  assign out_count    = count_q;
  assign out_overflow = ovf_q;

endmodule

// File: tb/tb_mult_accumulator.sv
// Scoreboard bench: a frame-level reference model queues expected results; a monitor checks handoffs.
// Runs with ACC_W=9 so overflow and MULT_ACC_SATURATE_EN behaviour are reachable.
module tb_mult_accumulator;

  localparam int PROD_W = 8;
  localparam int ACC_W  = 9;
  localparam int LEN    = 4;
  localparam int CNT_W  = $clog2(LEN + 1);
  localparam int MAXV   = (1 << ACC_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [PROD_W-1:0] in_product = '0;
  logic              in_last = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [ACC_W-1:0]  out_sum;
  logic [CNT_W-1:0]  out_count;
  logic              out_overflow;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int sum;
    int cnt;
    bit ovf;
  } exp_t;
  exp_t exp_q[$];

  int m_sum = 0;
  int m_cnt = 0;
  bit m_ovf = 1'b0;

  always #5 clk = ~clk;

  mult_accumulator #(
    .PROD_W(PROD_W),
    .ACC_W (ACC_W),
    .LEN   (LEN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_product  (in_product),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_count   (out_count),
    .out_overflow(out_overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Frame-level reference: running sum with wrap or clamp, frame closes at LEN or on last.
  task automatic model_beat(input int p, input bit l);
    exp_t e;
    m_sum = m_sum + p;
    if (m_sum > MAXV) begin
      m_ovf = 1'b1;
`ifdef MULT_ACC_SATURATE_EN
      m_sum = MAXV;
`else
      m_sum = m_sum - (MAXV + 1);
`endif
    end
    m_cnt++;
    if (m_cnt == LEN || l) begin
      e.sum = m_sum;
      e.cnt = m_cnt;
      e.ovf = m_ovf;
      exp_q.push_back(e);
      m_sum = 0;
      m_cnt = 0;
      m_ovf = 1'b0;
    end
  endtask

  // Entered 1 time unit after a rising edge; samples in_ready late in the cycle.
  task automatic cyc(input bit v, input int p, input bit l, input bit ordy, output bit acc);
    in_valid   = v;
    in_product = PROD_W'(p);
    in_last    = l;
    out_ready  = ordy;
    #6;
    acc = v && (in_ready === 1'b1);
    if (acc) model_beat(p, l);
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int p, input bit l, input bit ordy);
    bit acc = 1'b0;
    int n = 0;
    while (!acc && n < 50) begin
      cyc(1'b1, p, l, ordy, acc);
      n++;
    end
    if (!acc) begin
      vectors++;
      miscompares++;
      $display("FAIL beat_timeout: got no accept in %0d cycles, expected accept of %0d", n, p);
    end
  endtask

  task automatic idle(input int n, input bit ordy);
    bit acc;
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b0, ordy, acc);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL spurious_out_valid: got out_valid=1 sum=%0d, expected no result", out_sum);
      end else begin
        chk("out_sum", out_sum, exp_q[0].sum);
        chk("out_count", out_count, exp_q[0].cnt);
        chk("out_overflow", out_overflow, exp_q[0].ovf);
        if (out_ready === 1'b1) begin
          $display("frame out: sum=%0d count=%0d ovf=%0b", out_sum, out_count, out_overflow);
          void'(exp_q.pop_front());
        end else begin
          chk("in_ready_in_hold", in_ready, 0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_sum", out_sum, 0);
    chk("reset_out_count", out_count, 0);
    chk("reset_out_overflow", out_overflow, 0);
    chk("reset_in_ready", in_ready, 1);

    // Full-length frame, then a short frame closed by in_last.
    beat(3, 1'b0, 1'b1); beat(5, 1'b0, 1'b1); beat(7, 1'b0, 1'b1); beat(9, 1'b0, 1'b1);
    idle(2, 1'b1);
    beat(10, 1'b0, 1'b1); beat(20, 1'b1, 1'b1);
    idle(2, 1'b1);

    // Overflow of the 9-bit accumulator.
    beat(255, 1'b0, 1'b1); beat(255, 1'b0, 1'b1); beat(255, 1'b1, 1'b1);
    idle(2, 1'b1);

    // Backpressure in HOLD: beats offered but refused, outputs held.
    beat(1, 1'b0, 1'b0); beat(2, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 77, 1'b0, 1'b0, acc);
      chk("hold_refuses_beat", acc, 0);
    end
    cyc(1'b0, 0, 1'b0, 1'b1, acc);
    chk("valid_drops_after_handoff", out_valid, 0);

    // Handoff and new beat in the same cycle.
    beat(10, 1'b0, 1'b0); beat(20, 1'b1, 1'b0);
    cyc(1'b1, 42, 1'b0, 1'b1, acc);
    chk("zero_bubble_accept", acc, 1);
    beat(8, 1'b1, 1'b1);
    idle(2, 1'b1);

    // Reset mid-frame discards partial state.
    beat(1, 1'b0, 1'b1); beat(2, 1'b0, 1'b1);
    in_valid = 1'b0;
    rst = 1'b1;
    m_sum = 0; m_cnt = 0; m_ovf = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_out_sum", out_sum, 0);
    chk("midreset_out_count", out_count, 0);
    rst = 1'b0;
    beat(1, 1'b0, 1'b1); beat(1, 1'b0, 1'b1); beat(1, 1'b0, 1'b1); beat(1, 1'b0, 1'b1);
    idle(2, 1'b1);

    // Randomized traffic with random backpressure and early closes.
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 255), $urandom_range(0, 5) == 0,
          $urandom_range(0, 2) != 0, acc);
    end
    idle(10, 1'b1);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
